act_requant_pipe: RTL and testbench
===================================

# act_requant_pipe

Pipelined, multi-lane activation and requantisation stage between the convolution accumulators and the 8-bit feature-map buffer. Each lane takes a signed accumulator word and applies a rounding right-shift. It then applies ReLU or capped ReLU and saturates the result to unsigned OUT_W. Beats move with a valid/ready handshake, and the block counts per-frame saturation events so firmware can tune the shift.

## Interface
- IN_W, 24, signed accumulator width per lane
- OUT_W, 8, unsigned activation width per lane
- LANES, 4, parallel channels per beat
- SHIFT_W, 5, width of cfg_shift (shift range 0..IN_W-1)
- CNT_W, 16, width of saturation counter
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- cfg_mode  in  1  0 = ReLU + saturate to 2^OUT_W-1; 1 = capped ReLU at cfg_cap
- cfg_shift  in  SHIFT_W  right-shift amount, round-half-up
- cfg_cap  in  OUT_W  upper clamp for mode 1
- s_valid  in  1  input beat valid
- s_ready  out  1  block accepts beat
- s_data  in  LANES*IN_W  lane i at [i*IN_W +: IN_W], signed
- s_last  in  1  last beat of frame
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts
- m_data  out  LANES*OUT_W  lane i at [i*OUT_W +: OUT_W]
- m_last  out  1  s_last delayed with its beat
- frame_sat  out  CNT_W  saturated-lane count of last completed frame
- frame_done  out  1  one-cycle pulse when frame_sat updates

## Operation
- Stage 1 (shift): r = (x + rnd) >>> cfg_shift, where rnd = 0 if shift = 0, else 1 << (shift-1). Compute at IN_W+1 bits so x + rnd never overflows. The shift is arithmetic.
- Stage 2 (activate): r ≤ 0 -> 0. For r > 0, limit L = 2^OUT_W-1 (mode 0) or cfg_cap (mode 1). r > L -> L with the lane's sat flag set; otherwise r[OUT_W-1:0].
- Mode 1 with cfg_cap = 0 gives all-zero output, and a lane with r > 0 counts as saturated.
- cfg_* is sampled in stage 1 with the beat and carried forward. Changing cfg between beats therefore affects only later beats, with no flush needed.
- Saturation counter: on each output handshake (m_valid & m_ready), add popcount(sat flags) to sat_cnt. The counter sticks at 2^CNT_W-1.
- On a handshake with m_last: frame_sat <= sat_cnt + that beat's popcount (saturating), frame_done pulses, and sat_cnt clears to 0 in the same cycle.

## Timing
- Reset values: m_valid=0, m_data=0, m_last=0, frame_sat=0, frame_done=0, sat_cnt=0, all stage valids 0.
- s_ready is 1 out of reset. The reset clears in-flight beats and those beats are discarded.
- Latency is 2 cycles from s_valid & s_ready to m_valid while m_ready is held high. Throughput is 1 beat/cycle.
- Global enable en = !m_valid | m_ready. Both stage registers load only when en. s_ready = en (combinational from m_ready, no skid buffer).
- While m_valid & !m_ready, m_data and m_last are held stable and the stages hold. A bubble in stage 1 is not collapsed during the stall.
- frame_done is registered and rises the cycle after the m_last handshake. frame_sat keeps its value until the next frame completes.
- A single-beat frame (s_last on every beat) gives frame_done on every output handshake.

## Structure
- A shared package holds the mode encoding (MODE_RELU = 0, MODE_CAP = 1) and the lane slice helper. The codebase feature-width constants IN_W and OUT_W are defaults there.
- The natural sub-module is act_lane, one lane's combinational shift, round, clamp and sat flag, instantiated LANES times by generate. The top level owns the pipeline registers, handshake and counter.

## Test plan
- Mode 0, shift 0, lane 0 = 100, -50, 0, 255, 256, 1000, -1 -> 100, 0, 0, 255, 255, 255, 0. The sat count for that 7-beat frame is 2.
- Shift 4: 24 -> 2, 23 -> 1, 8 -> 1, 7 -> 0, -24 -> 0. Shift 23 with input 2^23-1 -> 1 and no overflow.
- Mode 1, cap 96: 200 -> 96 (sat), 96 -> 96 (not sat), 50 -> 50. Cap 0 with input 5 -> 0, sat counted.
- Backpressure: stream 6 beats with m_ready low for 3 cycles mid-stream. m_data stays stable, no beat is lost or duplicated, order is preserved, and s_ready is low during the stall.
- Frames: frame of 3 beats × 4 lanes with 5 saturated lanes -> frame_sat = 5 with a 1-cycle frame_done. The next frame with none saturated -> frame_sat = 0. Force the counter to 2^CNT_W-1 and confirm it sticks.
- Assert rst_n low mid-frame with 2 beats in flight: outputs go to 0 immediately (async). After release, the first new beat emerges after 2 cycles and the counter starts at 0.

Source files
------------

// File: rtl/act_requant_pipe_pkg.sv
// Shared definitions for the activation/requantisation pipeline.
// Holds the default feature widths, the mode encoding and the lane slice
// helper used to locate a lane inside a packed multi-lane bus.
package act_requant_pipe_pkg;

  localparam int DEF_IN_W    = 24;  // signed accumulator width per lane
  localparam int DEF_OUT_W   = 8;   // unsigned activation width per lane
  localparam int DEF_LANES   = 4;   // channels per beat
  localparam int DEF_SHIFT_W = 5;   // width of the shift amount
  localparam int DEF_CNT_W   = 16;  // saturation counter width

  typedef enum logic {
    MODE_RELU = 1'b0,  // ReLU, saturate to 2^OUT_W-1
    MODE_CAP  = 1'b1   // capped ReLU at cfg_cap
  } mode_e;

  // Bit offset of a lane in a packed bus whose lanes are w bits wide.
  function automatic int lane_base(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/act_requant_pipe_if.sv
// Single valid/ready stream: data plus an end-of-frame marker.
// Handshake: a beat transfers on a rising clk edge where valid && ready.
// The master holds valid, data and last stable until that edge; ready may
// depend combinationally on the slave's state but never on valid.
// Ports: valid, data, last (master -> slave), ready (slave -> master).
interface act_requant_pipe_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/act_lane.sv
// One lane of the requantiser, purely combinational.
// Front half (stage 1): round-half-up arithmetic right shift of x.
//   x, shift -> r (IN_W+1 bits, so x + rnd cannot overflow)
// Back half (stage 2): ReLU / capped ReLU with saturation flag.
//   r_in, mode, cap -> y, sat
// The top level registers r between the two halves.
module act_lane
  import act_requant_pipe_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic signed [IN_W-1:0] x,
  input  logic [SHIFT_W-1:0]     shift,
  output logic signed [IN_W:0]   r,
  input  logic signed [IN_W:0]   r_in,
  input  mode_e                  mode,
  input  logic [OUT_W-1:0]       cap,
  output logic [OUT_W-1:0]       y,
  output logic                   sat
);

  localparam logic signed [IN_W:0] ONE = 1;

  logic signed [IN_W:0] x_ext;
  logic signed [IN_W:0] rnd;
  logic signed [IN_W:0] sum;
  logic [IN_W:0]        limit;

  always_comb begin
    x_ext = {x[IN_W-1], x};
    rnd   = '0;
    if (shift != '0) begin
      rnd = ONE << (shift - SHIFT_W'(1));
    end
    sum = x_ext + rnd;
    r   = sum >>> shift;
  end

  always_comb begin
    limit = (mode == MODE_CAP) ? {{(IN_W + 1 - OUT_W){1'b0}}, cap}
                               : {{(IN_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};
    y   = '0;
    sat = 1'b0;
    // Non-positive values clamp to zero and never count as saturated.
    if (!r_in[IN_W] && (r_in != '0)) begin
      if ($unsigned(r_in) > limit) begin
        y   = limit[OUT_W-1:0];
        sat = 1'b1;
      end else begin
        y = r_in[OUT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/act_requant_pipe.sv
// Two-stage multi-lane activation/requantisation pipeline.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_mode/shift/cap    configuration, sampled with each accepted beat
//   s_if (slave)          LANES x IN_W signed accumulators in, with last
//   m_if (master)         LANES x OUT_W unsigned activations out, with last
//   frame_sat             saturated-lane count of the last completed frame
//   frame_done            one-cycle pulse when frame_sat updates
// Both stages advance together on en = !m_valid | m_ready; s_ready = en.
module act_requant_pipe
  import act_requant_pipe_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int LANES   = DEF_LANES,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  mode_e              cfg_mode,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic [OUT_W-1:0]   cfg_cap,
  act_requant_pipe_if.slave  s_if,
  act_requant_pipe_if.master m_if,
  output logic [CNT_W-1:0]   frame_sat,
  output logic               frame_done
);

  logic                 en;
  logic                 hs;
  logic                 s1_valid;
  logic                 s1_last;
  mode_e                s1_mode;
  logic [OUT_W-1:0]     s1_cap;
  logic signed [IN_W:0] s1_r   [LANES];
  logic signed [IN_W:0] r_next [LANES];
  logic [OUT_W-1:0]     y_next [LANES];
  logic [LANES-1:0]     sat_next;
  logic [LANES-1:0]     m_sat;
  logic [CNT_W-1:0]     sat_cnt;
  logic [CNT_W:0]       pop;
  logic [CNT_W:0]       sum_wide;
  logic [CNT_W-1:0]     sum_sat;

  assign en        = !m_if.valid || m_if.ready;
  assign s_if.ready = en;
  assign hs        = m_if.valid && m_if.ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .x     (s_if.data[lane_base(i, IN_W) +: IN_W]),
      .shift (cfg_shift),
      .r     (r_next[i]),
      .r_in  (s1_r[i]),
      .mode  (s1_mode),
      .cap   (s1_cap),
      .y     (y_next[i]),
      .sat   (sat_next[i])
    );
  end

  // Pipeline registers. A stage-1 bubble is carried forward rather than
  // collapsed, so a stall freezes the whole pipe as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_mode    <= MODE_RELU;
      s1_cap     <= '0;
      for (int i = 0; i < LANES; i++) s1_r[i] <= '0;
      m_if.valid <= 1'b0;
      m_if.data  <= '0;
      m_if.last  <= 1'b0;
      m_sat      <= '0;
    end else if (en) begin
      s1_valid   <= s_if.valid;
      s1_last    <= s_if.valid && s_if.last;
      s1_mode    <= cfg_mode;
      s1_cap     <= cfg_cap;
      for (int i = 0; i < LANES; i++) s1_r[i] <= r_next[i];
      m_if.valid <= s1_valid;
      m_if.last  <= s1_last;
      m_sat      <= sat_next;
      for (int i = 0; i < LANES; i++) begin
        m_if.data[lane_base(i, OUT_W) +: OUT_W] <= y_next[i];
      end
    end
  end

  // Saturating add of this beat's saturated-lane count.
  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + {{CNT_W{1'b0}}, m_sat[i]};
    end
    sum_wide = {1'b0, sat_cnt} + pop;
    sum_sat  = sum_wide[CNT_W] ? {CNT_W{1'b1}} : sum_wide[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt    <= '0;
      frame_sat  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (hs) begin
        if (m_if.last) begin
          frame_sat  <= sum_sat;
          frame_done <= 1'b1;
          sat_cnt    <= '0;
        end else begin
          sat_cnt <= sum_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_act_requant_pipe.sv
// Testbench for act_requant_pipe: table of directed beats with hand-computed
// outputs and per-frame saturation counts, plus sequences for backpressure,
// counter stickiness and asynchronous reset mid-frame.
module tb_act_requant_pipe;
  import act_requant_pipe_pkg::*;

  localparam int IN_W    = DEF_IN_W;
  localparam int OUT_W   = DEF_OUT_W;
  localparam int LANES   = DEF_LANES;
  localparam int SHIFT_W = DEF_SHIFT_W;
  localparam int CNT_W   = DEF_CNT_W;
  localparam int DW      = LANES * OUT_W;
  localparam int W       = DW + 1;  // {last, data}
  localparam int NVEC    = 16;

  logic               clk;
  logic               rst_n;
  mode_e              cfg_mode;
  logic [SHIFT_W-1:0] cfg_shift;
  logic [OUT_W-1:0]   cfg_cap;
  logic [CNT_W-1:0]   frame_sat;
  logic               frame_done;

  act_requant_pipe_if #(.DATA_W(LANES * IN_W)) s_if ();
  act_requant_pipe_if #(.DATA_W(DW))           m_if ();

  act_requant_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_mode   (cfg_mode),
    .cfg_shift  (cfg_shift),
    .cfg_cap    (cfg_cap),
    .s_if       (s_if),
    .m_if       (m_if),
    .frame_sat  (frame_sat),
    .frame_done (frame_done)
  );

  typedef struct {
    mode_e                 mode;
    logic [SHIFT_W-1:0]    shift;
    logic [OUT_W-1:0]      cap;
    logic [LANES*IN_W-1:0] data;
    logic                  last;
    logic [DW-1:0]         exp;
    logic [CNT_W-1:0]      fsat;
  } vec_t;

  vec_t           tbl [NVEC];
  logic [W-1:0]   exp_q[$];
  logic [CNT_W-1:0] fq[$];
  logic [W-1:0]   head;
  logic           mon_en;
  logic           done_due;
  int             cyc;
  int             errors;
  int             checks;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- helpers / driver ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [LANES*IN_W-1:0] pack4(input int l0, input int l1,
                                                  input int l2, input int l3);
    logic [LANES*IN_W-1:0] p;
    p = {l3[IN_W-1:0], l2[IN_W-1:0], l1[IN_W-1:0], l0[IN_W-1:0]};
    return p;
  endfunction

  // Present one beat and hold it until accepted; expected output is queued
  // at the negedge before the accepting edge.
  task automatic send(input mode_e mode, input logic [SHIFT_W-1:0] shift,
                      input logic [OUT_W-1:0] cap, input logic [LANES*IN_W-1:0] data,
                      input logic last, input logic [DW-1:0] exp,
                      input logic [CNT_W-1:0] fsat);
    int   waits;
    logic acc;
    cfg_mode   = mode;
    cfg_shift  = shift;
    cfg_cap    = cap;
    s_if.valid = 1'b1;
    s_if.data  = data;
    s_if.last  = last;
    waits = 0;
    acc   = 1'b0;
    while (!acc && waits < 200) begin
      @(negedge clk);
      acc = s_if.ready;
      if (acc) begin
        exp_q.push_back({last, exp});
        if (last) fq.push_back(fsat);
      end
      @(posedge clk);
      #1;
      waits++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %0h not accepted in %0d cycles", data, waits);
    end
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fq.size() != 0 || done_due) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL %s_drain: %0d beats and %0d frames still outstanding",
               name, exp_q.size(), fq.size());
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (frame_done || done_due) check("frame_done_timing", frame_done, done_due);
      if (frame_done) begin
        if (fq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_sat: unexpected frame_done with frame_sat=%0d", frame_sat);
        end else begin
          check("frame_sat", frame_sat, fq.pop_front());
        end
      end
      done_due = 1'b0;
      if (m_if.valid && m_if.ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m_data: unexpected beat %0h", m_if.data);
        end else begin
          head = exp_q.pop_front();
          check("m_data", m_if.data, head[DW-1:0]);
          check("m_last", m_if.last, head[DW]);
          done_due = m_if.last;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    int n;
    errors     = 0;
    checks     = 0;
    mon_en     = 1'b0;
    done_due   = 1'b0;
    rst_n      = 1'b0;
    cfg_mode   = MODE_RELU;
    cfg_shift  = '0;
    cfg_cap    = '0;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.last  = 1'b0;
    m_if.ready = 1'b1;

    // Frame A: mode 0, shift 0 (lane 0 carries the main pattern).
    tbl[0]  = '{MODE_RELU, 5'd0,  8'd0,  pack4(100, 1, 0, 17),        1'b0, 32'h1100_0164, 16'd0};
    tbl[1]  = '{MODE_RELU, 5'd0,  8'd0,  pack4(-50, -1, 0, 17),       1'b0, 32'h1100_0000, 16'd0};
    tbl[2]  = '{MODE_RELU, 5'd0,  8'd0,  pack4(0, 254, 0, 17),        1'b0, 32'h1100_FE00, 16'd0};
    tbl[3]  = '{MODE_RELU, 5'd0,  8'd0,  pack4(255, 0, 0, 17),        1'b0, 32'h1100_00FF, 16'd0};
    tbl[4]  = '{MODE_RELU, 5'd0,  8'd0,  pack4(256, 7, 0, 17),        1'b0, 32'h1100_07FF, 16'd0};
    tbl[5]  = '{MODE_RELU, 5'd0,  8'd0,  pack4(1000, -8388608, 0, 17), 1'b0, 32'h1100_00FF, 16'd0};
    tbl[6]  = '{MODE_RELU, 5'd0,  8'd0,  pack4(-1, 128, 0, 17),       1'b1, 32'h1100_8000, 16'd2};
    // Frame B: rounding shifts.
    tbl[7]  = '{MODE_RELU, 5'd4,  8'd0,  pack4(24, 23, 8, 7),         1'b0, 32'h0001_0102, 16'd0};
    tbl[8]  = '{MODE_RELU, 5'd4,  8'd0,  pack4(-24, 4095, 4096, -8),  1'b0, 32'h00FF_FF00, 16'd0};
    tbl[9]  = '{MODE_RELU, 5'd23, 8'd0,  pack4(8388607, -8388608, 4194304, 4194303),
                                                                      1'b1, 32'h0001_0001, 16'd2};
    // Frame C: capped ReLU, cap 0, then back to mode 0 mid-frame (5 sat lanes).
    tbl[10] = '{MODE_CAP,  5'd0,  8'd96, pack4(200, 96, 50, 97),      1'b0, 32'h6032_6060, 16'd0};
    tbl[11] = '{MODE_CAP,  5'd0,  8'd0,  pack4(5, 0, -3, 300),        1'b0, 32'h0000_0000, 16'd0};
    tbl[12] = '{MODE_RELU, 5'd1,  8'd0,  pack4(3, -3, 510, 511),      1'b1, 32'hFFFF_0002, 16'd5};
    // Single-beat frames.
    tbl[13] = '{MODE_RELU, 5'd0,  8'd0,  pack4(1, 2, 3, 4),           1'b1, 32'h0403_0201, 16'd0};
    tbl[14] = '{MODE_RELU, 5'd0,  8'd0,  pack4(255, 255, 255, 255),   1'b1, 32'hFFFF_FFFF, 16'd0};
    tbl[15] = '{MODE_RELU, 5'd0,  8'd0,  pack4(256, 0, 0, 0),         1'b1, 32'h0000_00FF, 16'd1};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid",    m_if.valid, 1'b0);
    check("rst_m_data",     m_if.data,  '0);
    check("rst_m_last",     m_if.last,  1'b0);
    check("rst_frame_sat",  frame_sat,  '0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_s_ready",    s_if.ready, 1'b1);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Table, streamed back to back.
    c0 = cyc;
    for (int i = 0; i < NVEC; i++) begin
      send(tbl[i].mode, tbl[i].shift, tbl[i].cap, tbl[i].data, tbl[i].last,
           tbl[i].exp, tbl[i].fsat);
    end
    check("throughput_cycles", cyc - c0, NVEC);
    wait_idle("table");

    // Backpressure: 6 beats, m_ready low for 3 cycles mid-stream.
    fork
      begin
        for (int b = 0; b < 6; b++) begin
          send(MODE_RELU, 5'd0, 8'd0, pack4(b + 10, b + 20, b + 30, b + 40), b == 5,
               {8'(b + 40), 8'(b + 30), 8'(b + 20), 8'(b + 10)}, 16'd0);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        m_if.ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_m_valid", m_if.valid, 1'b1);
          if (exp_q.size() != 0) check("stall_m_data", m_if.data, exp_q[0][DW-1:0]);
          check("stall_s_ready", s_if.ready, 1'b0);
          @(posedge clk);
        end
        #1;
        m_if.ready = 1'b1;
      end
    join
    wait_idle("backpressure");

    // Counter saturation: 16400 beats x 4 saturated lanes exceeds 2^16-1.
    for (int b = 0; b < 16400; b++) begin
      send(MODE_RELU, 5'd0, 8'd0, pack4(256, 256, 256, 256), b == 16399,
           32'hFFFF_FFFF, 16'hFFFF);
    end
    send(MODE_RELU, 5'd0, 8'd0, pack4(256, 0, 0, 0), 1'b1, 32'h0000_00FF, 16'd1);
    wait_idle("counter");

    // Reset mid-frame: one saturated beat counted, then two beats in flight.
    send(MODE_RELU, 5'd0, 8'd0, pack4(256, 256, 0, 0), 1'b0, 32'h0000_FFFF, 16'd0);
    wait_idle("pre_reset");
    send(MODE_RELU, 5'd0, 8'd0, pack4(1, 1, 1, 1), 1'b0, 32'h0101_0101, 16'd0);
    send(MODE_RELU, 5'd0, 8'd0, pack4(2, 2, 2, 2), 1'b0, 32'h0202_0202, 16'd0);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async_m_valid",    m_if.valid, 1'b0);
    check("async_m_data",     m_if.data,  '0);
    check("async_m_last",     m_if.last,  1'b0);
    check("async_frame_sat",  frame_sat,  '0);
    check("async_frame_done", frame_done, 1'b0);
    check("async_s_ready",    s_if.ready, 1'b1);
    exp_q.delete();
    fq.delete();
    done_due = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // First beat after reset: latency 2, counter restarted from 0.
    cfg_mode   = MODE_RELU;
    cfg_shift  = '0;
    cfg_cap    = '0;
    s_if.valid = 1'b1;
    s_if.data  = pack4(0, 0, 0, 300);
    s_if.last  = 1'b1;
    exp_q.push_back({1'b1, 32'hFF00_0000});
    fq.push_back(16'd1);
    c0 = cyc;
    @(posedge clk);
    #1;
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    n = 0;
    while (!m_if.valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("post_reset_latency", cyc - c0, 2);
    wait_idle("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
